exc_sequencer: RTL and testbench
================================

Name: exc_sequencer

Overview:
- Exception/interrupt sequencer for the pipelined LEGv8 core.
- Consumes the main decoder's exception flags (NotAnInstr, ERet, EStatus) and the external interrupt line.
- Drains the pipeline, redirects the PC to the exception vector, latches ELR/ESR, and returns to the saved PC on ERET.
- Sits between the decode stage and the PC/fetch mux; the MRS datapath reads ELR/ESR from it.

Parameters:
- N, 64, PC/ELR width in bits.
- EXC_VECTOR, 64'h0000_0000_0000_00D8, handler entry address.
- FLUSH_CYCLES, 3, pipeline drain cycles before redirect (legal range 1..7).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- ExtIRQ  in  1  external interrupt request, level, held until ExtIAck
- NotAnInstr  in  1  decode-stage invalid-opcode flag
- EStatus  in  4  decode-stage status code (4'b0010 = invalid opcode)
- ERet  in  1  ERET committing this cycle
- DecPC  in  N  PC of the instruction currently in decode
- Flush  out  1  squash all fetch/decode/execute stage registers
- PCRedirect  out  1  fetch loads PCTarget next edge
- PCTarget  out  N  redirect address
- ExtIAck  out  1  one-cycle interrupt acknowledge
- ELR  out  N  exception link register
- ESR  out  4  exception syndrome register
- InHandler  out  1  high while an exception is being serviced

Behaviour:
- Reset (async, any state): state=RUN, cnt=0, ELR=0, ESR=0, cause=0; all 1-bit outputs 0; PCTarget=0.
- Registered state, combinational outputs from state only. No input reaches an output combinationally.
- FSM states: RUN, DRAIN, VECTOR, HANDLER, RETURN.
- RUN:
  - NotAnInstr=1 takes priority over ExtIRQ. Capture ELR<=DecPC, ESR<=EStatus, cause<=SYNC, cnt<=0, go DRAIN.
  - Else ExtIRQ=1: capture ELR<=DecPC, ESR<=4'b0001, cause<=IRQ, cnt<=0, go DRAIN.
  - ERet in RUN is ignored: no redirect, no state change.
- DRAIN:
  - Flush=1 every cycle; cnt increments.
  - When cnt==FLUSH_CYCLES-1, go VECTOR. Total FLUSH_CYCLES cycles in DRAIN.
  - ExtIRQ/NotAnInstr/ERet are ignored in DRAIN.
- VECTOR: exactly one cycle.
  - PCRedirect=1, PCTarget=EXC_VECTOR, Flush=1.
  - ExtIAck=1 iff cause==IRQ.
  - Next state HANDLER.
- HANDLER:
  - InHandler=1; interrupts masked; ExtIRQ is not sampled.
  - NotAnInstr=1 sets ESR[3] (double-fault, sticky until next capture). No redirect, ELR unchanged.
  - ERet=1: go RETURN. ERet and NotAnInstr in the same cycle: ESR[3] set AND go RETURN.
- RETURN: exactly one cycle.
  - PCRedirect=1, PCTarget=ELR, Flush=1, InHandler=1.
  - Next state RUN.
  - A pending ExtIRQ is taken at the earliest on the first RUN cycle after RETURN, so at least one instruction at ELR reaches decode before a new DRAIN.
- Latency from trigger sample edge:
  - DRAIN cycles 1..FLUSH_CYCLES.
  - VECTOR at cycle FLUSH_CYCLES+1.
  - First handler fetch at FLUSH_CYCLES+2.
- PCTarget=0 whenever PCRedirect=0.
- ELR/ESR hold their values outside capture events and are readable in all states.
- Reset asserted mid-DRAIN/HANDLER: immediate return to RUN with reset values; no ExtIAck or redirect is issued afterwards.
- cnt is 3 bits and never wraps; it is cleared on entry to DRAIN.

Test Plan:
- Invalid opcode: reset, release; at cycle 5 drive NotAnInstr=1, EStatus=4'b0010, DecPC=64'h40 -> Flush high cycles 6-8, PCRedirect=1 with PCTarget=64'hD8 at cycle 9, ExtIAck=0, ELR=64'h40, ESR=4'b0010, InHandler=1 from cycle 10.
- IRQ + ERET: hold ExtIRQ=1 with DecPC=64'h100 -> ExtIAck single pulse coinciding with the VECTOR cycle, ESR=4'b0001; then ERet=1 in HANDLER -> next cycle PCRedirect=1, PCTarget=64'h100, then RUN with InHandler=0.
- Priority: NotAnInstr=1 and ExtIRQ=1 in the same RUN cycle -> ESR=4'b0010, no ExtIAck; ExtIRQ still high after RETURN -> new DRAIN starts exactly 1 cycle after the first RUN cycle, ELR=new DecPC.
- Masking/double fault: in HANDLER drive ExtIRQ=1 for 10 cycles plus NotAnInstr=1 once -> no Flush, no redirect, ESR=4'b1010, ELR unchanged.
- Reset mid-operation: assert reset asynchronously (between edges) during DRAIN cycle 2 -> all outputs 0 immediately; after release, no redirect occurs without a new trigger.
- ERET outside handler: ERet=1 in RUN -> PCRedirect stays 0, state remains RUN, ELR/ESR unchanged.

Source files
------------

// File: rtl/exc_sequencer.sv
// Exception/interrupt sequencer: drains the pipeline, vectors to the handler, latches ELR/ESR, returns on ERET.
// Latency: DRAIN for FLUSH_CYCLES cycles after the trigger edge, VECTOR next, handler fetch after that; no backpressure.
module exc_sequencer #(
   parameter int unsigned     N            = 64,
   parameter logic [N-1:0]    EXC_VECTOR   = N'(64'h0000_0000_0000_00D8),
   parameter int unsigned     FLUSH_CYCLES = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ExtIRQ,
   input  logic         NotAnInstr,
   input  logic [3:0]   EStatus,
   input  logic         ERet,
   input  logic [N-1:0] DecPC,
   output logic         Flush,
   output logic         PCRedirect,
   output logic [N-1:0] PCTarget,
   output logic         ExtIAck,
   output logic [N-1:0] ELR,
   output logic [3:0]   ESR,
   output logic         InHandler
);

   typedef enum logic [2:0] {
      RUN     = 3'd0,
      DRAIN   = 3'd1,
      VECTOR  = 3'd2,
      HANDLER = 3'd3,
      RETURN  = 3'd4
   } state_t;

   typedef enum logic {
      SYNC = 1'b0,
      IRQ  = 1'b1
   } cause_t;

   localparam logic [3:0] ESR_IRQ   = 4'b0001;
   localparam logic [2:0] CNT_LAST  = 3'(FLUSH_CYCLES - 1);

   state_t        state, state_nxt;
   cause_t        cause, cause_nxt;
   logic [2:0]    cnt, cnt_nxt;
   logic [N-1:0]  elr, elr_nxt;
   logic [3:0]    esr, esr_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
         cause <= SYNC;
         cnt   <= '0;
         elr   <= '0;
         esr   <= '0;
      end else begin
         state <= state_nxt;
         cause <= cause_nxt;
         cnt   <= cnt_nxt;
         elr   <= elr_nxt;
         esr   <= esr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cause_nxt = cause;
      cnt_nxt   = cnt;
      elr_nxt   = elr;
      esr_nxt   = esr;

      case (state)
         RUN: begin
            // Synchronous faults win so the offending PC is the one reported.
            if (NotAnInstr) begin
               elr_nxt   = DecPC;
               esr_nxt   = EStatus;
               cause_nxt = SYNC;
               cnt_nxt   = '0;
               state_nxt = DRAIN;
            end else if (ExtIRQ) begin
               elr_nxt   = DecPC;
               esr_nxt   = ESR_IRQ;
               cause_nxt = IRQ;
               cnt_nxt   = '0;
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (cnt == CNT_LAST) begin
               state_nxt = VECTOR;
            end else begin
               cnt_nxt = cnt + 3'd1;
            end
         end
         VECTOR: begin
            state_nxt = HANDLER;
         end
         HANDLER: begin
            // Interrupts are masked here; a nested invalid opcode only marks a double fault.
            if (NotAnInstr) begin
               esr_nxt = esr | 4'b1000;
            end
            if (ERet) begin
               state_nxt = RETURN;
            end
         end
         RETURN: begin
            state_nxt = RUN;
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   always_comb begin
      Flush      = 1'b0;
      PCRedirect = 1'b0;
      PCTarget   = '0;
      ExtIAck    = 1'b0;
      InHandler  = 1'b0;

      case (state)
         DRAIN: begin
            Flush = 1'b1;
         end
         VECTOR: begin
            Flush      = 1'b1;
            PCRedirect = 1'b1;
            PCTarget   = EXC_VECTOR;
            ExtIAck    = (cause == IRQ);
         end
         HANDLER: begin
            InHandler = 1'b1;
         end
         RETURN: begin
            Flush      = 1'b1;
            PCRedirect = 1'b1;
            PCTarget   = elr;
            InHandler  = 1'b1;
         end
         default: begin
            Flush = 1'b0;
         end
      endcase
   end

   assign ELR = elr;
   assign ESR = esr;

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer with a cycle-offset reference model checked every cycle.
module tb_exc_sequencer;

   localparam int          N  = 64;
   localparam int          FC = 3;
   localparam logic [63:0] VEC = 64'hD8;

   logic          clk = 1'b0;
   logic          reset;
   logic          ExtIRQ, NotAnInstr, ERet;
   logic [3:0]    EStatus;
   logic [N-1:0]  DecPC;
   logic          Flush, PCRedirect, ExtIAck, InHandler;
   logic [N-1:0]  PCTarget, ELR;
   logic [3:0]    ESR;

   int tests = 0;
   int fails = 0;

   exc_sequencer #(.N(N), .EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .reset(reset), .ExtIRQ(ExtIRQ), .NotAnInstr(NotAnInstr),
      .EStatus(EStatus), .ERet(ERet), .DecPC(DecPC), .Flush(Flush),
      .PCRedirect(PCRedirect), .PCTarget(PCTarget), .ExtIAck(ExtIAck),
      .ELR(ELR), .ESR(ESR), .InHandler(InHandler)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an exception episode is described by its trigger cycle and,
   // once ERET is seen, the cycle of the return; the phase is plain offset arithmetic.
   int          cyc, t0, ret_cyc;
   bit          active, m_irq;
   logic [63:0] m_elr;
   logic [3:0]  m_esr;

   function automatic int phase(input int c);
      int k;
      if (!active) return 0;
      if (ret_cyc == c) return 4;
      k = c - t0;
      if (k >= 1 && k <= FC) return 1;
      if (k == FC + 1) return 2;
      return 3;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc = 0; t0 = 0; ret_cyc = -1; active = 0; m_irq = 0;
         m_elr = '0; m_esr = '0;
      end else begin
         case (phase(cyc))
            0: begin
               if (NotAnInstr || ExtIRQ) begin
                  active = 1; t0 = cyc; ret_cyc = -1; m_elr = DecPC;
                  m_irq = !NotAnInstr;
                  m_esr = NotAnInstr ? EStatus : 4'b0001;
               end
            end
            3: begin
               if (NotAnInstr) m_esr[3] = 1'b1;
               if (ERet && ret_cyc < 0) ret_cyc = cyc + 1;
            end
            4: active = 0;
            default: ;
         endcase
         cyc++;
      end
   end

   always @(negedge clk) begin
      int p;
      p = phase(cyc);
      chk("m_flush", Flush,      (p == 1 || p == 2 || p == 4));
      chk("m_redir", PCRedirect, (p == 2 || p == 4));
      chk("m_tgt",   PCTarget,   (p == 2) ? VEC : (p == 4) ? m_elr : 64'h0);
      chk("m_ack",   ExtIAck,    (p == 2 && m_irq));
      chk("m_inh",   InHandler,  (p == 3 || p == 4));
      chk("m_elr",   ELR,        m_elr);
      chk("m_esr",   ESR,        m_esr);
   end

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; ExtIRQ = 0; NotAnInstr = 0; ERet = 0; EStatus = '0; DecPC = '0;
      repeat (3) step();
      chk("rst_elr", ELR, 0);
      chk("rst_flush", Flush, 0);
      reset = 1'b0;
      repeat (4) step();

      // Invalid opcode
      NotAnInstr = 1; EStatus = 4'b0010; DecPC = 64'h40;
      step(); NotAnInstr = 0; EStatus = 0; DecPC = 0;
      for (int i = 1; i <= FC; i++) begin
         if (i > 1) step();
         chk("A_drain_flush", Flush, 1);
         chk("A_drain_redir", PCRedirect, 0);
      end
      step();
      chk("A_vec_redir", PCRedirect, 1);
      chk("A_vec_tgt", PCTarget, 64'hD8);
      chk("A_vec_ack", ExtIAck, 0);
      step();
      chk("A_inh", InHandler, 1);
      chk("A_elr", ELR, 64'h40);
      chk("A_esr", ESR, 4'b0010);
      chk("A_hnd_flush", Flush, 0);
      ERet = 1; step(); ERet = 0;
      chk("A_ret_redir", PCRedirect, 1);
      chk("A_ret_tgt", PCTarget, 64'h40);
      step();
      chk("A_run_inh", InHandler, 0);

      // Interrupt then ERET
      ExtIRQ = 1; DecPC = 64'h100;
      step(); DecPC = 0;
      repeat (FC) step();
      chk("B_ack", ExtIAck, 1);
      chk("B_vec_tgt", PCTarget, 64'hD8);
      ExtIRQ = 0;
      step();
      chk("B_ack_single", ExtIAck, 0);
      chk("B_esr", ESR, 4'b0001);
      chk("B_elr", ELR, 64'h100);
      ERet = 1; step(); ERet = 0;
      chk("B_ret_redir", PCRedirect, 1);
      chk("B_ret_tgt", PCTarget, 64'h100);
      step();
      chk("B_run_inh", InHandler, 0);
      chk("B_run_redir", PCRedirect, 0);

      // Priority, then interrupt still pending after return
      NotAnInstr = 1; ExtIRQ = 1; EStatus = 4'b0010; DecPC = 64'h200;
      step(); NotAnInstr = 0; EStatus = 0;
      repeat (FC) step();
      chk("C_ack", ExtIAck, 0);
      step();
      chk("C_esr", ESR, 4'b0010);
      chk("C_elr", ELR, 64'h200);
      ERet = 1; step(); ERet = 0; DecPC = 64'h300;
      step();
      chk("C_run_flush", Flush, 0);
      chk("C_run_inh", InHandler, 0);
      step();
      chk("C_redrain", Flush, 1);
      DecPC = 0;
      repeat (FC) step();
      chk("C_ack2", ExtIAck, 1);
      ExtIRQ = 0;
      step();
      chk("C_elr2", ELR, 64'h300);
      chk("C_esr2", ESR, 4'b0001);
      ERet = 1; step(); ERet = 0;
      step();

      // Masking and double fault
      NotAnInstr = 1; EStatus = 4'b0010; DecPC = 64'h500;
      step(); NotAnInstr = 0; EStatus = 0; DecPC = 0;
      repeat (FC + 1) step();
      ExtIRQ = 1;
      for (int i = 0; i < 10; i++) begin
         if (i == 3) NotAnInstr = 1;
         step();
         NotAnInstr = 0;
         chk("D_flush", Flush, 0);
         chk("D_redir", PCRedirect, 0);
      end
      ExtIRQ = 0;
      chk("D_esr", ESR, 4'b1010);
      chk("D_elr", ELR, 64'h500);
      chk("D_inh", InHandler, 1);
      ERet = 1; NotAnInstr = 1; step(); ERet = 0; NotAnInstr = 0;
      chk("D_ret_redir", PCRedirect, 1);
      chk("D_ret_tgt", PCTarget, 64'h500);
      step();

      // Reset during DRAIN cycle 2
      ExtIRQ = 1; DecPC = 64'h600;
      step(); step();
      #2 reset = 1'b1;
      #1;
      chk("E_flush", Flush, 0);
      chk("E_redir", PCRedirect, 0);
      chk("E_inh", InHandler, 0);
      chk("E_ack", ExtIAck, 0);
      chk("E_elr", ELR, 0);
      chk("E_esr", ESR, 0);
      ExtIRQ = 0; DecPC = 0;
      step(); reset = 1'b0;
      repeat (8) begin
         step();
         chk("E_no_redir", PCRedirect, 0);
         chk("E_no_ack", ExtIAck, 0);
      end

      // ERET outside the handler
      ERet = 1; step(); ERet = 0;
      chk("F_redir", PCRedirect, 0);
      chk("F_flush", Flush, 0);
      chk("F_inh", InHandler, 0);
      chk("F_elr", ELR, 0);
      chk("F_esr", ESR, 0);
      step();
      chk("F_redir2", PCRedirect, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
